stream_burst_ctrl: RTL and testbench

Frame-aligned acquisition sequencer between the sensor receive path (clk_pix domain) and the downstream sync buffer. It gates fval/lval/data so that only complete frames pass, in continuous mode or in burst mode, where exactly N whole frames pass per start command. Stream enable, acquisition start and encrypt status come from the register block. Start and stop take effect only at fval edges; a frame is never truncated or partially emitted.

---
 rtl/stream_burst_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_stream_burst_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_burst_ctrl.sv
// Frame-aligned acquisition gate: passes only whole sensor frames, either
// continuously or as bursts of N frames per start command.
module stream_burst_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WD     = 16
) (
  input  logic                  clk_pix,
  input  logic                  reset_pix_n,
  input  logic                  i_fval,
  input  logic                  i_lval,
  input  logic [DATA_WIDTH-1:0] i_pix_data,
  input  logic                  i_stream_enable,
  input  logic                  i_acquisition_start,
  input  logic                  i_encrypt_state,
  input  logic                  i_acq_mode,
  input  logic                  i_burst_start,
  input  logic [CNT_WD-1:0]     i_burst_num,
  output logic                  o_fval,
  output logic                  o_lval,
  output logic [DATA_WIDTH-1:0] o_pix_data,
  output logic                  o_burst_busy,
  output logic                  o_burst_done,
  output logic [CNT_WD-1:0]     o_frame_cnt
);

  localparam logic [CNT_WD-1:0]     CNT_ZERO = {CNT_WD{1'b0}};
  localparam logic [CNT_WD-1:0]     CNT_ONE  = {{(CNT_WD-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] PIX_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PASS = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    fval_d_r;
  logic                    seen_low_r;
  logic [CNT_WD-1:0]       remaining_r;
  logic [CNT_WD-1:0]       frame_cnt_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    abort_pend_r;
  logic                    fval_r;
  logic                    lval_r;
  logic [DATA_WIDTH-1:0]   pix_r;

  logic                    rise_s;
  logic                    fall_s;
  logic                    gate_en_s;
  logic                    start_cond_s;
  logic                    pass_en_s;
  logic                    frame_end_s;
  logic                    accept_s;
  logic                    last_s;
  logic                    abort_s;

  // seen_low_r keeps a frame already running at reset release from looking like a rise
  assign rise_s       = i_fval & ~fval_d_r & seen_low_r;
  assign fall_s       = ~i_fval & fval_d_r;
  assign gate_en_s    = i_stream_enable & i_acquisition_start & i_encrypt_state;
  assign start_cond_s = gate_en_s & (~i_acq_mode | busy_r);
  assign frame_end_s  = (state_r == S_PASS) & fall_s;
  assign accept_s     = i_burst_start & ~busy_r & i_acq_mode & (i_burst_num != CNT_ZERO);
  assign last_s       = frame_end_s & busy_r & (remaining_r == CNT_ONE);
  assign abort_s      = busy_r & ~i_stream_enable;

  // Frame-valid edge history
  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) begin
      fval_d_r   <= 1'b0;
      seen_low_r <= 1'b0;
    end else begin
      fval_d_r <= i_fval;
      if (!i_fval) begin
        seen_low_r <= 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: enter on a qualified rise, leave on the frame's fall
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (rise_s && start_cond_s) begin
          state_nxt_s = S_PASS;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PASS: begin
        if (fall_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_PASS;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Pass enable, including the rise cycle that starts a frame
  always_comb begin
    pass_en_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (rise_s && start_cond_s) begin
          pass_en_s = 1'b1;
        end else begin
          pass_en_s = 1'b0;
        end
      end
      S_PASS:  pass_en_s = 1'b1;
      default: pass_en_s = 1'b0;
    endcase
  end

  // Gated video outputs, one cycle behind the sensor
  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) begin
      fval_r <= 1'b0;
      lval_r <= 1'b0;
      pix_r  <= PIX_ZERO;
    end else begin
      fval_r <= i_fval & pass_en_s;
      lval_r <= i_lval & i_fval & pass_en_s;
      pix_r  <= pass_en_s ? i_pix_data : PIX_ZERO;
    end
  end

  // Passed-frame counter, wraps naturally
  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) begin
      frame_cnt_r <= CNT_ZERO;
    end else if (frame_end_s) begin
      frame_cnt_r <= frame_cnt_r + CNT_ONE;
    end
  end

  // Burst bookkeeping; an abort seen mid-frame is held until that frame closes
  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) begin
      remaining_r  <= CNT_ZERO;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      abort_pend_r <= 1'b0;
    end else begin
      done_r <= last_s;
      if (accept_s) begin
        remaining_r  <= i_burst_num;
        busy_r       <= 1'b1;
        abort_pend_r <= 1'b0;
      end else if (last_s) begin
        remaining_r  <= CNT_ZERO;
        busy_r       <= 1'b0;
        abort_pend_r <= 1'b0;
      end else if (frame_end_s && busy_r) begin
        if (abort_pend_r || !i_stream_enable) begin
          remaining_r  <= CNT_ZERO;
          busy_r       <= 1'b0;
          abort_pend_r <= 1'b0;
        end else begin
          remaining_r <= remaining_r - CNT_ONE;
        end
      end else if (abort_s && (state_r == S_IDLE)) begin
        remaining_r  <= CNT_ZERO;
        busy_r       <= 1'b0;
        abort_pend_r <= 1'b0;
      end else if (abort_s) begin
        abort_pend_r <= 1'b1;
      end
    end
  end

  assign o_fval       = fval_r;
  assign o_lval       = lval_r;
  assign o_pix_data   = pix_r;
  assign o_burst_busy = busy_r;
  assign o_burst_done = done_r;
  assign o_frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_stream_burst_ctrl.sv
// Scoreboard bench for stream_burst_ctrl: each driven frame that should pass
// pushes its expected output shape; a monitor pops and compares output frames.
module tb_stream_burst_ctrl;

  localparam int DW = 10;
  localparam int CW = 16;
  localparam int LINES = 8;
  localparam int PX = 16;

  logic          clk_pix = 1'b0;
  logic          reset_pix_n;
  logic          i_fval, i_lval;
  logic [DW-1:0] i_pix_data;
  logic          i_stream_enable, i_acquisition_start, i_encrypt_state;
  logic          i_acq_mode, i_burst_start;
  logic [CW-1:0] i_burst_num;
  logic          o_fval, o_lval;
  logic [DW-1:0] o_pix_data;
  logic          o_burst_busy, o_burst_done;
  logic [CW-1:0] o_frame_cnt;

  typedef struct {
    int start;
    int len;
    int beats;
    int sum;
  } exp_frame_t;

  exp_frame_t exp_q[$];
  exp_frame_t m_exp;
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  exp_cnt = 0;
  int  exp_done = 0;
  int  done_cnt = 0;
  int  done_cyc = -1;
  int  ofall_cyc = -2;
  bit  in_frame = 1'b0;
  bit  prev_done = 1'b0;
  int  m_start, m_len, m_beats, m_sum;

  always #5 clk_pix = ~clk_pix;
  always @(posedge clk_pix) cyc <= cyc + 1;

  stream_burst_ctrl #(.DATA_WIDTH(DW), .CNT_WD(CW)) dut (
    .clk_pix(clk_pix), .reset_pix_n(reset_pix_n),
    .i_fval(i_fval), .i_lval(i_lval), .i_pix_data(i_pix_data),
    .i_stream_enable(i_stream_enable), .i_acquisition_start(i_acquisition_start),
    .i_encrypt_state(i_encrypt_state), .i_acq_mode(i_acq_mode),
    .i_burst_start(i_burst_start), .i_burst_num(i_burst_num),
    .o_fval(o_fval), .o_lval(o_lval), .o_pix_data(o_pix_data),
    .o_burst_busy(o_burst_busy), .o_burst_done(o_burst_done), .o_frame_cnt(o_frame_cnt)
  );

  // Output monitor: collects output frames and compares them with the scoreboard
  always @(negedge clk_pix) begin
    if (!reset_pix_n) begin
      in_frame  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (o_fval !== 1'b1) begin
        checks++;
        if (o_lval !== 1'b0 || o_pix_data !== {DW{1'b0}} || o_fval !== 1'b0) begin
          failures++;
          $display("FAIL idle_outputs fval=%b lval=%b data=%0h exp fval=0 lval=0 data=0 cyc=%0d",
                   o_fval, o_lval, o_pix_data, cyc);
        end
      end
      if (o_fval === 1'b1 && !in_frame) begin
        in_frame = 1'b1; m_start = cyc; m_len = 0; m_beats = 0; m_sum = 0;
      end
      if (o_fval === 1'b1) begin
        m_len++;
        if (o_lval === 1'b1) begin
          m_beats++;
          m_sum += int'(o_pix_data);
        end
      end else if (in_frame) begin
        in_frame  = 1'b0;
        ofall_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame got start=%0d len=%0d exp no frame", m_start, m_len);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_start != m_exp.start || m_len != m_exp.len ||
              m_beats != m_exp.beats || m_sum != m_exp.sum) begin
            failures++;
            $display("FAIL frame_shape got start=%0d len=%0d beats=%0d sum=%0d exp start=%0d len=%0d beats=%0d sum=%0d",
                     m_start, m_len, m_beats, m_sum, m_exp.start, m_exp.len, m_exp.beats, m_exp.sum);
          end
        end
      end
      if (o_burst_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        checks++;
        if (prev_done) begin
          failures++;
          $display("FAIL done_width got done high 2 cycles exp 1 cycle at cyc=%0d", cyc);
        end
      end
      prev_done = (o_burst_done === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_pix);
  endtask

  // Drives one frame; frames expected to pass are pushed with their shape
  task automatic send_frame(input int lines, input int px, input bit pass);
    exp_frame_t e;
    e.start = 0; e.len = 0; e.beats = 0; e.sum = 0;
    @(negedge clk_pix);
    e.start = cyc + 1;
    i_fval = 1'b1; i_lval = 1'b0; i_pix_data = DW'($urandom_range(0, 1023)); e.len++;
    @(negedge clk_pix);
    i_pix_data = DW'($urandom_range(0, 1023)); e.len++;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < px; p++) begin
        @(negedge clk_pix);
        i_lval = 1'b1; i_pix_data = DW'($urandom_range(0, 1023));
        e.len++; e.beats++; e.sum += int'(i_pix_data);
      end
      for (int b = 0; b < 3; b++) begin
        @(negedge clk_pix);
        i_lval = 1'b0; i_pix_data = DW'($urandom_range(0, 1023)); e.len++;
      end
    end
    @(negedge clk_pix);
    i_fval = 1'b0; i_lval = 1'b0; i_pix_data = {DW{1'b0}};
    if (pass) begin
      exp_q.push_back(e);
      exp_cnt++;
    end
  endtask

  task automatic pulse_start(input logic [CW-1:0] num);
    @(negedge clk_pix);
    i_burst_start = 1'b1; i_burst_num = num;
    @(negedge clk_pix);
    i_burst_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_pix);
    reset_pix_n = 1'b0;
    exp_cnt = 0;
    repeat (2) @(negedge clk_pix);
    reset_pix_n = 1'b1;
  endtask

  task automatic end_check(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_frames got pending=%0d exp 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (o_frame_cnt !== CW'(exp_cnt)) begin
      failures++;
      $display("FAIL %s_frame_cnt got %0d exp %0d", name, o_frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    reset_pix_n = 1'b0;
    i_fval = 1'b0; i_lval = 1'b0; i_pix_data = {DW{1'b0}};
    i_stream_enable = 1'b0; i_acquisition_start = 1'b0; i_encrypt_state = 1'b0;
    i_acq_mode = 1'b0; i_burst_start = 1'b0; i_burst_num = {CW{1'b0}};
    repeat (3) @(negedge clk_pix);
    reset_pix_n = 1'b1;
    @(negedge clk_pix);
    checks++;
    if ({o_fval, o_lval, o_burst_busy, o_burst_done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got %b exp 0000", {o_fval, o_lval, o_burst_busy, o_burst_done});
    end
    checks++;
    if (o_pix_data !== {DW{1'b0}} || o_frame_cnt !== {CW{1'b0}}) begin
      failures++;
      $display("FAIL reset_values got data=%0h cnt=%0d exp 0 0", o_pix_data, o_frame_cnt);
    end
  endtask

  task automatic test_continuous();
    i_stream_enable = 1'b1; i_acquisition_start = 1'b1; i_encrypt_state = 1'b1;
    i_acq_mode = 1'b0;
    idle(2);
    for (int f = 0; f < 30; f++) begin
      send_frame(LINES, PX, 1'b1);
      idle(4);
    end
    idle(3);
    end_check("continuous");
  endtask

  task automatic test_gate_toggle();
    fork
      begin
        send_frame(LINES, PX, 1'b1);
        idle(10);
        send_frame(LINES, PX, 1'b0);
        idle(10);
        send_frame(LINES, PX, 1'b1);
        idle(5);
      end
      begin
        repeat (50) @(negedge clk_pix);
        i_stream_enable = 1'b0;
        repeat (150) @(negedge clk_pix);
        i_stream_enable = 1'b1;
      end
    join
    end_check("gate_toggle");
  endtask

  task automatic test_burst();
    i_acq_mode = 1'b1;
    idle(3);
    pulse_start(CW'(3));
    checks++;
    if (o_burst_busy !== 1'b1) begin
      failures++;
      $display("FAIL burst_busy_set got %b exp 1", o_burst_busy);
    end
    for (int f = 0; f < 3; f++) begin
      send_frame(LINES, PX, 1'b1);
      idle(4);
    end
    exp_done++;
    checks++;
    if (done_cnt != exp_done || done_cyc != ofall_cyc || o_burst_busy !== 1'b0) begin
      failures++;
      $display("FAIL burst_done got cnt=%0d cyc=%0d busy=%b exp cnt=%0d cyc=%0d busy=0",
               done_cnt, done_cyc, o_burst_busy, exp_done, ofall_cyc);
    end
    send_frame(LINES, PX, 1'b0);
    idle(4);
    checks++;
    if (done_cnt != exp_done) begin
      failures++;
      $display("FAIL burst_extra_done got %0d exp %0d", done_cnt, exp_done);
    end
    end_check("burst");
  endtask

  task automatic test_burst_ignore();
    pulse_start(CW'(0));
    checks++;
    if (o_burst_busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_num_start got busy=%b exp 0", o_burst_busy);
    end
    send_frame(LINES, PX, 1'b0);
    idle(4);
    pulse_start(CW'(2));
    idle(2);
    pulse_start(CW'(7));
    checks++;
    if (o_burst_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_restart got %b exp 1", o_burst_busy);
    end
    send_frame(LINES, PX, 1'b1);
    idle(4);
    send_frame(LINES, PX, 1'b1);
    idle(4);
    send_frame(LINES, PX, 1'b0);
    idle(4);
    exp_done++;
    checks++;
    if (done_cnt != exp_done || o_burst_busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_done got cnt=%0d busy=%b exp cnt=%0d busy=0", done_cnt, o_burst_busy, exp_done);
    end
    end_check("burst_ignore");
  endtask

  task automatic test_back_to_back();
    fork
      begin
        send_frame(LINES, PX, 1'b0);
        send_frame(LINES, PX, 1'b1);
        send_frame(LINES, PX, 1'b0);
      end
      begin
        @(negedge clk_pix);
        i_burst_start = 1'b1; i_burst_num = CW'(1);
        @(negedge clk_pix);
        i_burst_start = 1'b0;
      end
    join
    idle(5);
    exp_done++;
    checks++;
    if (done_cnt != exp_done || done_cyc != ofall_cyc || o_burst_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done got cnt=%0d cyc=%0d busy=%b exp cnt=%0d cyc=%0d busy=0",
               done_cnt, done_cyc, o_burst_busy, exp_done, ofall_cyc);
    end
    end_check("back_to_back");
  endtask

  task automatic test_burst_abort();
    do_reset();
    idle(2);
    pulse_start(CW'(5));
    send_frame(LINES, PX, 1'b1);
    idle(4);
    send_frame(LINES, PX, 1'b1);
    idle(4);
    fork
      send_frame(LINES, PX, 1'b1);
      begin
        repeat (30) @(negedge clk_pix);
        i_stream_enable = 1'b0;
      end
    join
    idle(4);
    checks++;
    if (o_burst_busy !== 1'b0 || done_cnt != exp_done || o_frame_cnt !== CW'(3)) begin
      failures++;
      $display("FAIL abort_state got busy=%b done=%0d cnt=%0d exp busy=0 done=%0d cnt=3",
               o_burst_busy, done_cnt, o_frame_cnt, exp_done);
    end
    i_stream_enable = 1'b1;
    send_frame(LINES, PX, 1'b0);
    idle(4);
    end_check("burst_abort");
  endtask

  task automatic test_reset_mid_frame();
    i_acq_mode = 1'b0;
    idle(2);
    fork
      send_frame(LINES, PX, 1'b0);
      begin
        repeat (40) @(negedge clk_pix);
        checks++;
        if (o_fval !== 1'b1) begin
          failures++;
          $display("FAIL pre_reset_fval got %b exp 1", o_fval);
        end
        #2;
        reset_pix_n = 1'b0;
        exp_cnt = 0;
        #1;
        checks++;
        if ({o_fval, o_lval} !== 2'b00 || o_pix_data !== {DW{1'b0}} || o_frame_cnt !== {CW{1'b0}}) begin
          failures++;
          $display("FAIL async_reset got fval=%b lval=%b data=%0h cnt=%0d exp all 0",
                   o_fval, o_lval, o_pix_data, o_frame_cnt);
        end
        repeat (3) @(negedge clk_pix);
        reset_pix_n = 1'b1;
      end
    join
    idle(3);
    send_frame(LINES, PX, 1'b1);
    idle(5);
    end_check("reset_mid_frame");
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gate_toggle();
    test_burst();
    test_burst_ignore();
    test_back_to_back();
    test_burst_abort();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
